// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT sequencer: frame size, index width,
// default sample width, controller state encoding and the 3-bit index reversal
// that maps between natural and DIF-core output order.
package fft8_pkg;

    localparam int FFT_N  = 8;
    localparam int IDX_W  = 3;
    localparam int DEF_DW = 32;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    // Reverse the bit order of a 3-bit slot/bin index.
    function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft8_ctrl.sv
// fft8_ctrl: frame sequencer around a combinational 8-point DIF butterfly core.
// Collects 8 samples, presents them to the core from registers, waits CORE_LAT
// extra cycles, captures the core result and streams the 8 bins out.
// Build option FFT8_BITREV_EN: when defined, outputs leave in natural frequency
// order (obuf[bitrev3(k)], m_idx=k); otherwise in core slot order (obuf[k],
// m_idx=bitrev3(k)).
module fft8_ctrl
    import fft8_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int CORE_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_real,
    input  logic [DW-1:0]     s_imag,
    output logic [8*DW-1:0]   core_in_real,
    output logic [8*DW-1:0]   core_in_imag,
    input  logic [8*DW-1:0]   core_out_real,
    input  logic [8*DW-1:0]   core_out_imag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_real,
    output logic [DW-1:0]     m_imag,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_last,
    output logic              busy,
    output logic              frame_done
);

    // Slot of obuf carried by the k-th output transfer.
    function automatic logic [IDX_W-1:0] out_slot(input logic [IDX_W-1:0] k);
`ifdef FFT8_BITREV_EN
        return bitrev3(k);
`else
        return k;
`endif
    endfunction

    // Frequency bin label of the k-th output transfer.
    function automatic logic [IDX_W-1:0] out_bin(input logic [IDX_W-1:0] k);
`ifdef FFT8_BITREV_EN
        return k;
`else
        return bitrev3(k);
`endif
    endfunction

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(CORE_LAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

    state_t             state_r;
    logic [2*DW-1:0]    ibuf_r [FFT_N];
    logic [2*DW-1:0]    obuf_r [FFT_N];
    logic [IDX_W-1:0]   wr_idx_r;
    logic [IDX_W-1:0]   rd_idx_r;
    logic [LAT_W-1:0]   lat_cnt_r;

    logic               s_ready_r;
    logic               m_valid_r;
    logic [DW-1:0]      m_real_r;
    logic [DW-1:0]      m_imag_r;
    logic [IDX_W-1:0]   m_idx_r;
    logic               m_last_r;
    logic               busy_r;
    logic               frame_done_r;

    logic               accept_s;
    logic               xfer_s;
    logic [IDX_W-1:0]   rd_next_s;
    logic [IDX_W-1:0]   next_slot_s;
    logic [IDX_W-1:0]   first_slot_s;

    assign s_ready    = s_ready_r;
    assign m_valid    = m_valid_r;
    assign m_real     = m_real_r;
    assign m_imag     = m_imag_r;
    assign m_idx      = m_idx_r;
    assign m_last     = m_last_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Core inputs come only from the frame buffer, never straight from s_*.
    for (genvar j = 0; j < FFT_N; j++) begin : g_core_in
        assign core_in_real[j*DW +: DW] = ibuf_r[j][2*DW-1:DW];
        assign core_in_imag[j*DW +: DW] = ibuf_r[j][DW-1:0];
    end

    // Handshake qualifiers and the obuf slot selection for the next output.
    always_comb begin
        accept_s     = s_valid && s_ready_r;
        xfer_s       = m_valid_r && m_ready;
        rd_next_s    = rd_idx_r + 3'd1;
        next_slot_s  = out_slot(rd_next_s);
        first_slot_s = out_slot(3'd0);
    end

    // Controller FSM with buffers, counters and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= LOAD;
            wr_idx_r     <= 3'd0;
            rd_idx_r     <= 3'd0;
            lat_cnt_r    <= 4'd0;
            s_ready_r    <= 1'b0;
            m_valid_r    <= 1'b0;
            m_real_r     <= '0;
            m_imag_r     <= '0;
            m_idx_r      <= 3'd0;
            m_last_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            for (int j = 0; j < FFT_N; j++) begin
                ibuf_r[j] <= '0;
                obuf_r[j] <= '0;
            end
        end else if (flush) begin
            // Abort: buffer contents stay but are stale; counters restart.
            state_r      <= LOAD;
            wr_idx_r     <= 3'd0;
            rd_idx_r     <= 3'd0;
            lat_cnt_r    <= 4'd0;
            s_ready_r    <= 1'b1;
            m_valid_r    <= 1'b0;
            m_last_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                LOAD: begin
                    s_ready_r <= 1'b1;
                    if (accept_s) begin
                        ibuf_r[wr_idx_r] <= {s_real, s_imag};
                        if (wr_idx_r == LAST_IDX) begin
                            wr_idx_r  <= 3'd0;
                            lat_cnt_r <= LAT_INIT;
                            state_r   <= COMPUTE;
                            s_ready_r <= 1'b0;
                            busy_r    <= 1'b1;
                        end else begin
                            wr_idx_r <= wr_idx_r + 3'd1;
                        end
                    end
                end
                COMPUTE: begin
                    if (lat_cnt_r == 4'd0) begin
                        for (int j = 0; j < FFT_N; j++) begin
                            obuf_r[j] <= {core_out_real[j*DW +: DW],
                                          core_out_imag[j*DW +: DW]};
                        end
                        // First output is taken straight from the core so it
                        // is valid on the same edge obuf is loaded.
                        rd_idx_r  <= 3'd0;
                        state_r   <= UNLOAD;
                        m_valid_r <= 1'b1;
                        m_real_r  <= core_out_real[first_slot_s*DW +: DW];
                        m_imag_r  <= core_out_imag[first_slot_s*DW +: DW];
                        m_idx_r   <= out_bin(3'd0);
                        m_last_r  <= 1'b0;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end
                end
                UNLOAD: begin
                    if (xfer_s) begin
                        if (rd_idx_r == LAST_IDX) begin
                            rd_idx_r     <= 3'd0;
                            state_r      <= LOAD;
                            m_valid_r    <= 1'b0;
                            m_last_r     <= 1'b0;
                            busy_r       <= 1'b0;
                            s_ready_r    <= 1'b1;
                            frame_done_r <= 1'b1;
                        end else begin
                            rd_idx_r <= rd_next_s;
                            m_real_r <= obuf_r[next_slot_s][2*DW-1:DW];
                            m_imag_r <= obuf_r[next_slot_s][DW-1:0];
                            m_idx_r  <= out_bin(rd_next_s);
                            m_last_r <= (rd_next_s == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_r   <= LOAD;
                    m_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_ctrl.sv
// Self-checking bench for fft8_ctrl with an identity core (core_out = core_in)
// and CORE_LAT=3. Expected output order follows FFT8_BITREV_EN.
module tb_fft8_ctrl;
    import fft8_pkg::*;

    localparam int DW  = 32;
    localparam int LAT = 3;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_real;
    logic [DW-1:0]     s_imag;
    logic [8*DW-1:0]   core_in_real;
    logic [8*DW-1:0]   core_in_imag;
    logic [8*DW-1:0]   core_out_real;
    logic [8*DW-1:0]   core_out_imag;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_real;
    logic [DW-1:0]     m_imag;
    logic [2:0]        m_idx;
    logic              m_last;
    logic              busy;
    logic              frame_done;

    fft8_ctrl #(.DW(DW), .CORE_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
        .core_in_real(core_in_real), .core_in_imag(core_in_imag),
        .core_out_real(core_out_real), .core_out_imag(core_out_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_idx(m_idx), .m_last(m_last), .busy(busy), .frame_done(frame_done)
    );

    assign core_out_real = core_in_real;
    assign core_out_imag = core_in_imag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][DW-1:0] re;
        logic [7:0][DW-1:0] im;
        logic               stall;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    idx;
        logic          last;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[3];
    vec_t v_flush;
    vec_t v_junk;
    int   exp_slot[8];
    int   exp_bin[8];
    int   n_chk = 0;
    int   n_pass = 0;
    int   fd_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard consumer, stall-hold checker and frame_done counter.
    logic          hold_pend = 1'b0;
    logic [DW-1:0] h_re, h_im;
    logic [2:0]    h_idx;
    logic          h_last;
    always @(negedge clk) begin
        exp_t e;
        if (frame_done) fd_cnt++;
        if (hold_pend && m_valid) begin
            check("hold_data", {m_real, m_imag}, {h_re, h_im});
            check("hold_idx_last", {60'd0, m_idx, m_last}, {60'd0, h_idx, h_last});
        end
        hold_pend = rst_n && m_valid && !m_ready;
        h_re = m_real; h_im = m_imag; h_idx = m_idx; h_last = m_last;
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("out_data", {m_real, m_imag}, {e.re, e.im});
                check("out_idx", 64'(m_idx), 64'(e.idx));
                check("out_last", 64'(m_last), 64'(e.last));
            end
        end
    end

    task automatic send(input vec_t v, input int n, input bit push);
        int t;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_real  = v.re[i];
            s_imag  = v.im[i];
            t = 0;
            while (!s_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!s_ready) check("accept_timeout", 64'(s_ready), 64'd1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (push) begin
            for (int k = 0; k < 8; k++) begin
                e.re   = v.re[exp_slot[k]];
                e.im   = v.im[exp_slot[k]];
                e.idx  = 3'(exp_bin[k]);
                e.last = (k == 7);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_mvalid(output int c);
        c = 0;
        while (!m_valid && c < 20) begin
            check("compute_busy", 64'(busy), 64'd1);
            check("compute_s_ready", 64'(s_ready), 64'd0);
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic run_frame(input vec_t v);
        int  c;
        bit  done;
        m_ready = 1'b1;
        send(v, 8, 1'b1);
        wait_mvalid(c);
        check("latency", 64'(c), 64'(LAT + 1));
        c = 0;
        done = 1'b0;
        while (!done && c < 100) begin
            check("unload_busy", 64'(busy), 64'd1);
            check("unload_s_ready", 64'(s_ready), 64'd0);
            m_ready = v.stall ? ((c % 3) == 0) : 1'b1;
            @(posedge clk); #1;
            c++;
            if (frame_done) done = 1'b1;
        end
        m_ready = 1'b1;
        check("frame_done_seen", 64'(done), 64'd1);
        check("all_outputs", 64'(sb.size()), 64'd0);
        check("idle_s_ready", 64'(s_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_m_valid", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        check("frame_done_pulse", 64'(frame_done), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int c;
        int fd0;
`ifdef FFT8_BITREV_EN
        exp_slot = '{0, 4, 2, 6, 1, 5, 3, 7};
        exp_bin  = '{0, 1, 2, 3, 4, 5, 6, 7};
`else
        exp_slot = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_bin  = '{0, 4, 2, 6, 1, 5, 3, 7};
`endif
        for (int i = 0; i < 8; i++) begin
            vecs[0].re[i] = 32'(i + 1);
            vecs[0].im[i] = 32'(i + 10);
            vecs[1].re[i] = 32'hA5A5_0000 + 32'(i * 273);
            vecs[1].im[i] = 32'hFFFF_FFFF - 32'(i);
            vecs[2].re[i] = 32'h8000_0000 | 32'(i);
            vecs[2].im[i] = 32'h0000_0000 + 32'(i << 28);
            v_flush.re[i] = 32'(i + 21);
            v_flush.im[i] = 32'(i + 121);
            v_junk.re[i]  = 32'hDEAD_0000 + 32'(i);
            v_junk.im[i]  = 32'hBEEF_0000 + 32'(i);
        end
        vecs[0].stall = 1'b0;
        vecs[1].stall = 1'b1;
        vecs[2].stall = 1'b1;
        v_flush.stall = 1'b0;
        v_junk.stall  = 1'b0;

        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        s_real = '0; s_imag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_busy_done_last", {61'd0, busy, frame_done, m_last}, 64'd0);
        check("rst_core_in", {core_in_real[63:0]}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s_ready", 64'(s_ready), 64'd1);

        // Table-driven frames: plain, stalled, boundary values.
        for (int t = 0; t < 3; t++) run_frame(vecs[t]);

        // Partial frame aborted by flush, then a fresh frame.
        fd0 = fd_cnt;
        send(v_junk, 5, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_s_ready", 64'(s_ready), 64'd1);
        run_frame(v_flush);
        check("flush_frame_done_count", 64'(fd_cnt - fd0), 64'd1);

        // Flush during UNLOAD: m_valid drops next cycle, no frame_done.
        fd0 = fd_cnt;
        send(v_junk, 8, 1'b0);
        wait_mvalid(c);
        m_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        m_ready = 1'b1;
        check("uflush_m_valid", 64'(m_valid), 64'd0);
        check("uflush_busy", 64'(busy), 64'd0);
        check("uflush_s_ready", 64'(s_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("uflush_no_done", 64'(fd_cnt - fd0), 64'd0);

        // Async reset in the middle of UNLOAD.
        send(vecs[0], 8, 1'b1);
        m_ready = 1'b1;
        wait_mvalid(c);
        m_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", 64'(m_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_m_last", 64'(m_last), 64'd0);
        check("arst_s_ready", 64'(s_ready), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("arst_release_s_ready", 64'(s_ready), 64'd1);
        run_frame(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft8_ctrl.md
Name: fft8_ctrl

Overview:
- Sequencer for the combinational 8-point radix-2 DIF butterfly core `butterfly8`: 8 complex inputs, 32-bit real/imag each.
- Collects 8 samples from a valid/ready input stream into a frame buffer and drives the core's flattened input buses.
- Waits a programmable core latency, captures the core outputs, then streams 8 results out on a valid/ready interface.
- Sits between the sample source and downstream spectrum consumer; the butterfly core is instantiated beside it at top level.

Parameters:
- DW, 32, width of each real/imag component.
- CORE_LAT, 0, extra cycles to wait after frame load before capturing core outputs; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous abort; discards the current frame.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when high with s_valid.
- s_real  in  DW  input sample real part.
- s_imag  in  DW  input sample imaginary part.
- core_in_real  out  8*DW  to core; slot j at bits [j*DW +: DW].
- core_in_imag  out  8*DW  to core, same packing.
- core_out_real  in  8*DW  from core, same packing.
- core_out_imag  in  8*DW  from core, same packing.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accept.
- m_real  out  DW  output real part.
- m_imag  out  DW  output imaginary part.
- m_idx  out  3  frequency bin of the current output sample.
- m_last  out  1  high with the 8th output of a frame.
- busy  out  1  high in COMPUTE or UNLOAD.
- frame_done  out  1  one-cycle pulse after the 8th output transfer.

Behaviour:
- States: LOAD, COMPUTE, UNLOAD. Reset state is LOAD.
- Reset values:
  - All registers 0, including ibuf, obuf, wr_idx, rd_idx and lat_cnt.
  - m_valid, m_last, busy, frame_done are 0.
  - s_ready is 0 while rst_n is low.
- LOAD:
  - s_ready=1.
  - On each s_valid&&s_ready edge: ibuf[wr_idx]<={s_real,s_imag}, then wr_idx++.
  - On the accept with wr_idx==7: wr_idx<=0, lat_cnt<=CORE_LAT, go to COMPUTE.
- core_in_* is driven continuously from ibuf registers. There is no combinational path from s_* to the core.
- COMPUTE:
  - s_ready=0, busy=1.
  - Lasts CORE_LAT+1 cycles; lat_cnt decrements each cycle.
  - On the edge where lat_cnt==0: obuf<=core_out_*, rd_idx<=0, go to UNLOAD.
- Latency: first m_valid is high CORE_LAT+1 cycles after the edge that accepts the 8th input.
- UNLOAD:
  - m_valid=1; m_real/m_imag come from obuf (slot chosen per Optional Feature).
  - m_last=(rd_idx==7).
  - On m_valid&&m_ready: rd_idx++.
  - On the transfer with rd_idx==7: go to LOAD and pulse frame_done in the following cycle.
- Backpressure: outputs hold stable while m_valid&&!m_ready. No output is dropped or repeated.
- Half-duplex: no new input is accepted until UNLOAD finishes (s_ready=0 in COMPUTE/UNLOAD).
- flush (priority over all other events):
  - Next state is LOAD; wr_idx, rd_idx, lat_cnt <= 0.
  - m_valid drops next cycle; no frame_done.
  - ibuf/obuf contents are kept but treated as stale.
- Partial frame: a flush in LOAD discards the accepted samples, and the next accept writes slot 0.
- Async reset mid-frame behaves as flush plus full clear.
- Arithmetic: none. The controller only moves data; widths are passed through unchanged.

Optional Feature:
- Macro: FFT8_BITREV_EN.
- Defined:
  - Output order is natural frequency order.
  - The k-th output transfer carries obuf[bitrev3(k)], with m_idx=k.
  - This undoes the DIF core's bit-reversed output ordering.
- Undefined:
  - Output order is core slot order; the k-th transfer carries obuf[k].
  - m_idx=bitrev3(k), so the bin label is still correct.
- Timing and handshake are identical in both builds.

Decomposition:
- Package fft8_pkg:
  - constants FFT_N=8, IDX_W=3, default DW;
  - state enum {LOAD, COMPUTE, UNLOAD};
  - function bitrev3.
- No sub-module. Buffers, counters and FSM live in fft8_ctrl; the butterfly core stays a sibling instance.

Test Plan:
- Identity core stub (core_out=core_in), CORE_LAT=0, FFT8_BITREV_EN, inputs real 1..8 / imag 10..17, m_ready=1:
  - m_real sequence 1,5,3,7,2,6,4,8; m_imag 10,14,12,16,11,15,13,17;
  - m_idx 0..7; m_last on 8th; frame_done one cycle later.
- Same stimulus without FFT8_BITREV_EN:
  - m_real 1..8 in order; m_idx 0,4,2,6,1,5,3,7.
- CORE_LAT=3:
  - first m_valid exactly 4 cycles after the 8th input accept;
  - busy high throughout COMPUTE/UNLOAD; s_ready=0 until frame_done.
- m_ready toggled 1,0,0,1,… during UNLOAD:
  - each sample held stable while stalled; exactly 8 transfers; order unchanged.
- flush after 5 inputs accepted, then 8 fresh inputs 21..28:
  - output frame contains only 21..28; no frame_done for the aborted frame.
- rst_n pulled low mid-UNLOAD:
  - m_valid, busy, m_last go 0 immediately; after release, s_ready=1 and a full frame processes normally.
